i2s_transmitter: RTL and testbench

//  Single-channel I2S transmitter, the playback-side counterpart to the per-channel i2s_receiver.
//  - Accepts 32-bit sample words on a simple wen/wdata write port into an internal FWFT FIFO.
//  - Generates bclk/lrclk from clk and serializes alternating left/right samples as standard I2S.
//  - Instantiated N times under a transmitter wrapper that distributes bulk writes per channel.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_tx_fifo.sv | 58 +++++
 rtl/i2s_transmitter.sv | 171 +++++++++++++++++
 tb/tb_i2s_transmitter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types for the I2S transmit path: channel and transmitter state
// encodings, plus the default number of significant bits per sample.
package i2s_pkg;

    localparam int I2S_DATA_BIT_WIDTH_DEF = 24;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } channel_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the I2S serializer.
// The head word is always visible on head while the FIFO is not empty.
// A write while full is dropped, even if a pop happens in the same cycle.
module i2s_tx_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wen,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = wen && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    // Storage array; no reset needed, validity is tracked by level.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally for power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level      <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Single-channel I2S transmitter: buffers written samples in a FWFT FIFO,
// divides clk down to bclk and shifts alternating left/right slots out
// MSB first with the standard one-bclk delay after each lrclk change.
// Optional feature macro: I2S_TX_UNDERRUN_COUNT_EN adds a saturating
// underrun_count output counting slots started with the FIFO empty.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int C_S_TDATA_WIDTH    = 32,
    parameter int I2S_DATA_BIT_WIDTH = I2S_DATA_BIT_WIDTH_DEF,
    parameter int SLOT_BITS          = 32,
    parameter int BCLK_DIV           = 4,
    parameter int FIFO_DEPTH         = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               wen,
    input  logic [C_S_TDATA_WIDTH-1:0]         wdata,
    output logic                               w_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               bclk,
    output logic                               lrclk,
    output logic                               sdata,
    output logic                               error_full,
    output logic                               error_empty
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]                        underrun_count
`endif
);

    localparam int DW    = I2S_DATA_BIT_WIDTH;
    localparam int CNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int B_W   = $clog2(SLOT_BITS);

    tx_state_t        state_reg;
    tx_state_t        state_next;
    channel_t         upcoming_ch_reg;
    logic [CNT_W-1:0] div_cnt_reg;
    logic [B_W-1:0]   bit_idx_reg;
    logic [DW-1:0]    shift_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [DW-1:0]    fifo_head;

    logic             tick;
    logic             fall;
    logic             slot_start;
    logic             stop;
    logic             underrun;

    // Bits of the write word above the sample width carry no meaning.
    generate
        if (C_S_TDATA_WIDTH > DW) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^wdata[C_S_TDATA_WIDTH-1:DW];
        end
    endgenerate

    i2s_tx_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wen),
        .pop   (fifo_pop),
        .wdata (wdata[DW-1:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign w_ready = !fifo_full;

    // A slot boundary is the bclk falling edge at bit index 0. Stopping is
    // only allowed there when the next slot would be a left one, so frames
    // are never split.
    assign tick       = (state_reg == ST_RUN) && (div_cnt_reg == CNT_W'(BCLK_DIV - 1));
    assign fall       = tick && bclk;
    assign slot_start = fall && (bit_idx_reg == '0);
    assign stop       = slot_start && (upcoming_ch_reg == CH_LEFT) && !enable;
    assign fifo_pop   = slot_start && !stop && !fifo_empty;
    assign underrun   = slot_start && !stop && fifo_empty;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: start on enable, leave only at a frame boundary.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (enable) state_next = ST_RUN;
            ST_RUN:  if (stop)   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Divider, bit counter, lrclk and serializer; everything held at 0 in idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg     <= '0;
            bit_idx_reg     <= '0;
            bclk            <= 1'b0;
            lrclk           <= 1'b0;
            sdata           <= 1'b0;
            shift_reg       <= '0;
            upcoming_ch_reg <= CH_LEFT;
        end else if (state_reg != ST_RUN || stop) begin
            div_cnt_reg     <= '0;
            bit_idx_reg     <= '0;
            bclk            <= 1'b0;
            lrclk           <= 1'b0;
            sdata           <= 1'b0;
            upcoming_ch_reg <= CH_LEFT;
        end else begin
            if (tick) begin
                div_cnt_reg <= '0;
                bclk        <= ~bclk;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
            if (fall) begin
                bit_idx_reg <= (bit_idx_reg == B_W'(SLOT_BITS - 1)) ? '0 : bit_idx_reg + 1'b1;
                if (bit_idx_reg == '0) begin
                    // New slot: switch channel, load sample (zero on underrun),
                    // and emit the I2S delay bit.
                    lrclk           <= upcoming_ch_reg;
                    upcoming_ch_reg <= (upcoming_ch_reg == CH_LEFT) ? CH_RIGHT : CH_LEFT;
                    shift_reg       <= fifo_empty ? '0 : fifo_head;
                    sdata           <= 1'b0;
                end else if (bit_idx_reg <= B_W'(DW)) begin
                    sdata     <= shift_reg[DW-1];
                    shift_reg <= {shift_reg[DW-2:0], 1'b0};
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_full  <= 1'b0;
            error_empty <= 1'b0;
        end else begin
            if (wen && fifo_full) error_full  <= 1'b1;
            if (underrun)         error_empty <= 1'b1;
        end
    end

`ifdef I2S_TX_UNDERRUN_COUNT_EN
    // Saturating count of slots that started with no sample available.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= '0;
        end else if (underrun && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with a slot-decoding monitor and a
// scoreboard of expected (channel, sample) slots.
module tb_i2s_transmitter;

    localparam int DIV   = 2;
    localparam int SLOTB = 32;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wen;
    logic [31:0] wdata;
    logic        w_ready;
    logic [4:0]  fifo_level;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        error_full;
    logic        error_empty;
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;
`endif

    i2s_transmitter #(
        .C_S_TDATA_WIDTH    (32),
        .I2S_DATA_BIT_WIDTH (24),
        .SLOT_BITS          (SLOTB),
        .BCLK_DIV           (DIV),
        .FIFO_DEPTH         (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .wen         (wen),
        .wdata       (wdata),
        .w_ready     (w_ready),
        .fifo_level  (fifo_level),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .error_full  (error_full),
        .error_empty (error_empty)
`ifdef I2S_TX_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [23:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   slots_done = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic expect_slot(input logic ch, input logic [23:0] data);
        exp_t e;
        e.ch = ch;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: counts bclk falling edges since idle; bit b of a slot is the
    // sdata value presented after falling edge b. A slot is reported after
    // its last falling edge and checked against the scoreboard head.
    initial begin
        int          fall_cnt;
        int          low_run;
        int          b;
        logic        prev_bclk;
        logic        slot_ch;
        logic [31:0] slot_word;
        logic        lr_ok;
        exp_t        e;
        fall_cnt = 0; low_run = 0; prev_bclk = 1'b0;
        slot_ch = 1'b0; slot_word = '0; lr_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fall_cnt = 0;
                low_run = 0;
                prev_bclk = 1'b0;
            end else begin
                if (prev_bclk && !bclk) begin
                    b = fall_cnt % SLOTB;
                    if (b == 0) begin
                        slot_ch = lrclk;
                        slot_word = '0;
                        lr_ok = 1'b1;
                    end
                    if (lrclk !== slot_ch) lr_ok = 1'b0;
                    slot_word = {slot_word[30:0], sdata};
                    if (b == SLOTB - 1) begin
                        slots_done++;
                        check("slot_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("slot_channel", {31'd0, slot_ch}, {31'd0, e.ch});
                            check("slot_data", slot_word, {1'b0, e.data, 7'b0});
                            check("lrclk_stable", {31'd0, lr_ok}, 32'd1);
                        end
                        $display("slot %0d ch=%0d word=%08h", slots_done, slot_ch, slot_word);
                    end
                    fall_cnt++;
                end
                if (bclk) begin
                    low_run = 0;
                end else begin
                    low_run++;
                    if (low_run > 3 * DIV) fall_cnt = 0;
                end
                prev_bclk = bclk;
            end
        end
    end

    task automatic write_word(input logic [31:0] d);
        wdata = d;
        wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
        $display("write %08h level=%0d", d, fifo_level);
    endtask

    task automatic wait_slots(input int target);
        int n;
        n = 0;
        while (slots_done < target && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_slots", slots_done, target);
    endtask

    task automatic play(input int n);
        int start;
        start = slots_done;
        enable = 1'b1;
        wait_slots(start + n - 1);
        enable = 1'b0;
        wait_slots(start + n);
        repeat (40) @(posedge clk);
        #1;
        check("idle_bclk", {31'd0, bclk}, 32'd0);
        check("idle_lrclk", {31'd0, lrclk}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        wen = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int          s;
        int          n;
        logic [23:0] w;
        rst_n = 1'b0;
        enable = 1'b0;
        wen = 1'b0;
        wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_bclk", {31'd0, bclk}, 32'd0);
        check("rst_lrclk", {31'd0, lrclk}, 32'd0);
        check("rst_sdata", {31'd0, sdata}, 32'd0);
        check("rst_level", {27'd0, fifo_level}, 32'd0);
        check("rst_w_ready", {31'd0, w_ready}, 32'd1);
        check("rst_err_full", {31'd0, error_full}, 32'd0);
        check("rst_err_empty", {31'd0, error_empty}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame; upper write bits must be ignored
        write_word(32'hFFA5A5A5);
        write_word(32'h005A5A5A);
        check("basic_level", {27'd0, fifo_level}, 32'd2);
        expect_slot(1'b0, 24'hA5A5A5);
        expect_slot(1'b1, 24'h5A5A5A);
        play(2);
        check("basic_drained", {27'd0, fifo_level}, 32'd0);
        check("basic_no_underrun", {31'd0, error_empty}, 32'd0);

        // Stop requested early in the left slot; remaining words retained
        write_word(32'h111111);
        write_word(32'h222222);
        write_word(32'h333333);
        write_word(32'h444444);
        expect_slot(1'b0, 24'h111111);
        expect_slot(1'b1, 24'h222222);
        s = slots_done;
        enable = 1'b1;
        n = 0;
        while (fifo_level != 5'd3 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("stop_first_pop", {27'd0, fifo_level}, 32'd3);
        enable = 1'b0;
        wait_slots(s + 2);
        repeat (300) @(posedge clk);
        #1;
        check("stop_no_extra_slot", slots_done, s + 2);
        check("stop_retained", {27'd0, fifo_level}, 32'd2);
        check("stop_bclk_low", {31'd0, bclk}, 32'd0);
        check("stop_no_underrun", {31'd0, error_empty}, 32'd0);
        expect_slot(1'b0, 24'h333333);
        expect_slot(1'b1, 24'h444444);
        play(2);

        // Underrun: only a left word available
        write_word(32'h00ABCDEF);
        expect_slot(1'b0, 24'hABCDEF);
        expect_slot(1'b1, 24'h000000);
        play(2);
        check("underrun_flag", {31'd0, error_empty}, 32'd1);
`ifdef I2S_TX_UNDERRUN_COUNT_EN
        check("underrun_count", {16'd0, underrun_count}, 32'd1);
`endif

        // Reset in the middle of a slot
        for (int k = 0; k < 4; k++) write_word(32'h00C0FFEE + k);
        s = slots_done;
        enable = 1'b1;
        repeat (40) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_bclk", {31'd0, bclk}, 32'd0);
        check("midrst_lrclk", {31'd0, lrclk}, 32'd0);
        check("midrst_sdata", {31'd0, sdata}, 32'd0);
        check("midrst_level", {27'd0, fifo_level}, 32'd0);
        check("midrst_w_ready", {31'd0, w_ready}, 32'd1);
        check("midrst_err_empty", {31'd0, error_empty}, 32'd0);
        enable = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("midrst_no_slot", slots_done, s);

        // Overflow: 17 back-to-back writes without enable
        for (int k = 0; k < 17; k++) begin
            w = 24'h100000 + 24'(k) * 24'h010203;
            wdata = {8'h00, w};
            wen = 1'b1;
            if (k < 16) expect_slot(k[0], w);
            @(posedge clk); #1;
        end
        wen = 1'b0;
        check("ovf_level", {27'd0, fifo_level}, 32'd16);
        check("ovf_w_ready", {31'd0, w_ready}, 32'd0);
        check("ovf_err_full", {31'd0, error_full}, 32'd1);
        play(16);
        check("ovf_drained", {27'd0, fifo_level}, 32'd0);
        check("ovf_sb_empty", sb.size(), 0);

        // Write at full coinciding with the first slot pop
        do_reset();
        for (int k = 0; k < 16; k++) begin
            w = 24'hF00000 - 24'(k) * 24'h000111;
            expect_slot(k[0], w);
            write_word({8'h00, w});
        end
        check("sim_full_no_err", {31'd0, error_full}, 32'd0);
        check("sim_w_ready", {31'd0, w_ready}, 32'd0);
        s = slots_done;
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        wdata = 32'h00DEAD00;
        wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
        check("sim_err_full", {31'd0, error_full}, 32'd1);
        check("sim_level", {27'd0, fifo_level}, 32'd15);
        repeat (3) @(posedge clk);
        #1;
        check("sim_level_hold", {27'd0, fifo_level}, 32'd15);
        wait_slots(s + 15);
        enable = 1'b0;
        wait_slots(s + 16);
        repeat (40) @(posedge clk);
        #1;
        check("sim_drained", {27'd0, fifo_level}, 32'd0);
        check("sim_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
